// File: rtl/leaf_router.sv
// Single-flit leaf router: five input FIFOs (four NI leaves + uplink), per-output round-robin arbitration.
// Optional LEAF_ROUTER_DROP_CNT_EN builds a saturating counter of flits dropped at the uplink input.
module leaf_router #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned GROUP_ID   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DATA_W-1:0] loc_data_in,
    input  logic [3:0]          loc_valid_in,
    output logic [3:0]          loc_ready_out,
    output logic [4*DATA_W-1:0] loc_data_out,
    output logic [3:0]          loc_valid_out,
    input  logic [DATA_W-1:0]   up_data_in,
    input  logic                up_valid_in,
    output logic                up_ready_out,
    output logic [DATA_W-1:0]   up_data_out,
    output logic                up_valid_out,
    input  logic                up_ready_in,
    output logic [7:0]          drop_count
);
    localparam int unsigned N_IN   = 5;
    localparam int unsigned UP_IDX = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [DATA_W-1:0] mem_q      [N_IN][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q   [N_IN];
    logic [PTR_W-1:0]  wr_ptr_q   [N_IN];
    logic [CNT_W-1:0]  cnt_q      [N_IN];
    logic [IDX_W-1:0]  arb_ptr_q  [N_IN];
    logic [DATA_W-1:0] out_data_q [N_IN];
    logic [N_IN-1:0]   out_valid_q;

    logic [DATA_W-1:0] in_data_c   [N_IN];
    logic [DATA_W-1:0] head_c      [N_IN];
    logic [IDX_W-1:0]  dst_c       [N_IN];
    logic [IDX_W-1:0]  grant_idx_c [N_IN];
    logic [N_IN-1:0]   in_valid_c, ready_c, push_c, pop_c, req_c, drop_c, grant_vld_c;

    // Next index in the 5-entry round-robin ring, offset from a base.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N_IN) s = s - N_IN;
        return IDX_W'(s);
    endfunction

    // Input unpacking, push qualification and head routing.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            in_data_c[i] = loc_data_in[i*DATA_W +: DATA_W];
        end
        in_data_c[UP_IDX] = up_data_in;
        in_valid_c = {up_valid_in, loc_valid_in};
        for (int unsigned i = 0; i < N_IN; i++) begin
            ready_c[i] = (cnt_q[i] != CNT_W'(FIFO_DEPTH));
            push_c[i]  = in_valid_c[i] && ready_c[i];
            head_c[i]  = mem_q[i][rd_ptr_q[i]];
            drop_c[i]  = 1'b0;
            req_c[i]   = 1'b0;
            dst_c[i]   = IDX_W'(UP_IDX);
            if (head_c[i][DATA_W-1 -: 4] == 4'(GROUP_ID)) begin
                dst_c[i] = IDX_W'(head_c[i][DATA_W-5 -: 2]);
                req_c[i] = (cnt_q[i] != '0);
            end else if (i == UP_IDX) begin
                drop_c[i] = (cnt_q[i] != '0);
            end else begin
                req_c[i] = (cnt_q[i] != '0);
            end
        end
    end

    // Per-output round-robin search; dropped uplink heads pop without a grant.
    always_comb begin
        logic [IDX_W-1:0] c;
        c           = '0;
        grant_vld_c = '0;
        pop_c       = drop_c;
        for (int unsigned o = 0; o < N_IN; o++) begin
            grant_idx_c[o] = '0;
        end
        for (int unsigned o = 0; o < N_IN; o++) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                c = rr_idx(arb_ptr_q[o], k);
                if (!grant_vld_c[o] && (o != UP_IDX || up_ready_in) &&
                    req_c[c] && dst_c[c] == IDX_W'(o)) begin
                    grant_vld_c[o] = 1'b1;
                    grant_idx_c[o] = c;
                    pop_c[c]       = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (push_c[i]) mem_q[i][wr_ptr_q[i]] <= in_data_c[i];
        end
    end

    // FIFO bookkeeping, arbiter pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                rd_ptr_q[i]   <= '0;
                wr_ptr_q[i]   <= '0;
                cnt_q[i]      <= '0;
                arb_ptr_q[i]  <= '0;
                out_data_q[i] <= '0;
            end
            out_valid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (push_c[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                if (pop_c[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                if (push_c[i] && !pop_c[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end else if (!push_c[i] && pop_c[i]) begin
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
                end
                if (grant_vld_c[i]) begin
                    out_data_q[i] <= head_c[grant_idx_c[i]];
                    arb_ptr_q[i]  <= rr_idx(grant_idx_c[i], 1);
                end
            end
            out_valid_q <= grant_vld_c;
        end
    end

`ifdef LEAF_ROUTER_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_c[UP_IDX] && drop_cnt_q != 8'hFF) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_loc_out
        assign loc_data_out[g*DATA_W +: DATA_W] = out_data_q[g];
    end
    assign loc_valid_out = out_valid_q[3:0];
    assign up_data_out   = out_data_q[UP_IDX];
    assign up_valid_out  = out_valid_q[UP_IDX];
    assign loc_ready_out = ready_c[3:0];
    assign up_ready_out  = ready_c[UP_IDX];

endmodule

// File: tb/tb_leaf_router.sv
// Bench for leaf_router: directed scenarios plus random traffic, all checked against a queue-based model.
module tb_leaf_router;
    localparam int DATA_W   = 16;
    localparam int GROUP_ID = 2;
    localparam int DEPTH    = 4;
    localparam int DROP     = 5;
`ifdef LEAF_ROUTER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk, reset;
    logic [63:0] loc_data_in, loc_data_out;
    logic [3:0]  loc_valid_in, loc_ready_out, loc_valid_out;
    logic [15:0] up_data_in, up_data_out;
    logic        up_valid_in, up_ready_out, up_valid_out, up_ready_in;
    logic [7:0]  drop_count;

    leaf_router #(.DATA_W(DATA_W), .GROUP_ID(GROUP_ID), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .loc_data_in(loc_data_in), .loc_valid_in(loc_valid_in), .loc_ready_out(loc_ready_out),
        .loc_data_out(loc_data_out), .loc_valid_out(loc_valid_out),
        .up_data_in(up_data_in), .up_valid_in(up_valid_in), .up_ready_out(up_ready_out),
        .up_data_out(up_data_out), .up_valid_out(up_valid_out), .up_ready_in(up_ready_in),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    typedef logic [15:0] flit_q_t[$];
    flit_q_t     q [5];
    int          rr [5];
    logic [15:0] exp_data [5];
    logic [4:0]  exp_vld;
    int          exp_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flit(input int grp, input int leaf, input int tag);
        logic [3:0] g;
        logic [1:0] l;
        logic [9:0] t;
        g = 4'(grp);
        l = 2'(leaf);
        t = 10'(tag);
        return {g, l, t};
    endfunction

    // Destination of a head flit: 0..3 local leaf, 4 uplink, DROP discarded.
    function automatic int route(input int src, input logic [15:0] f);
        if (int'(f[15:12]) == GROUP_ID) return int'(f[11:10]);
        return (src == 4) ? DROP : 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            q[i].delete();
            rr[i] = 0;
            exp_data[i] = '0;
        end
        exp_vld  = '0;
        exp_drop = 0;
    endtask

    // One clock: check readies, advance the model across the edge, then check registered outputs.
    task automatic cycle();
        logic [15:0] din [5];
        logic [4:0]  vin, pop, rdy;
        bit          found;
        int          src;
        #1;
        for (int i = 0; i < 4; i++) din[i] = loc_data_in[i*16 +: 16];
        din[4] = up_data_in;
        vin = {up_valid_in, loc_valid_in};
        for (int i = 0; i < 5; i++) rdy[i] = (q[i].size() != DEPTH);
        chk("ready", 64'({up_ready_out, loc_ready_out}), 64'(rdy));
        pop = '0;
        exp_vld = '0;
        for (int o = 0; o < 5; o++) begin
            found = 1'b0;
            if (o != 4 || up_ready_in) begin
                for (int k = 0; k < 5; k++) begin
                    src = (rr[o] + k) % 5;
                    if (!found && q[src].size() > 0 && route(src, q[src][0]) == o) begin
                        found       = 1'b1;
                        pop[src]    = 1'b1;
                        exp_vld[o]  = 1'b1;
                        exp_data[o] = q[src][0];
                        rr[o]       = (src + 1) % 5;
                    end
                end
            end
        end
        if (q[4].size() > 0 && route(4, q[4][0]) == DROP) begin
            pop[4] = 1'b1;
            if (DROP_EN && exp_drop < 255) exp_drop++;
        end
        for (int i = 0; i < 5; i++) begin
            if (pop[i]) void'(q[i].pop_front());
            if (vin[i] && rdy[i]) q[i].push_back(din[i]);
        end
        @(posedge clk);
        #1;
        chk("valid", 64'({up_valid_out, loc_valid_out}), 64'(exp_vld));
        chk("loc_data", loc_data_out, {exp_data[3], exp_data[2], exp_data[1], exp_data[0]});
        chk("up_data", 64'(up_data_out), 64'(exp_data[4]));
        chk("drop_count", 64'(drop_count), 64'(exp_drop));
    endtask

    task automatic idle_inputs();
        loc_valid_in = '0;
        up_valid_in  = 1'b0;
    endtask

    initial begin
        int seq [4];
        seq = '{0, 2, 3, 4};
        reset = 1'b1;
        loc_data_in = '0; loc_valid_in = '0;
        up_data_in = '0; up_valid_in = 1'b0; up_ready_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_loc_ready", 64'(loc_ready_out), 64'hF);
        chk("rst_up_ready", 64'(up_ready_out), 64'h1);
        chk("rst_valids", 64'({up_valid_out, loc_valid_out}), 64'h0);
        chk("rst_data", loc_data_out ^ 64'(up_data_out), 64'h0);
        chk("rst_drop", 64'(drop_count), 64'h0);

        // Local route with loopback to leaf 1.
        loc_data_in[15:0] = 16'h2555; loc_valid_in = 4'b0001;
        cycle();
        idle_inputs();
        cycle();
        chk("local_valid", 64'({up_valid_out, loc_valid_out}), 64'h02);
        chk("local_data", 64'(loc_data_out[31:16]), 64'h2555);

        // Uplink route, then held by up_ready_in=0.
        loc_data_in[47:32] = 16'h4C01; loc_valid_in = 4'b0100;
        cycle();
        idle_inputs();
        cycle();
        chk("up_route", 64'({up_valid_out, up_data_out}), 64'h1_4C01);
        up_ready_in = 1'b0;
        loc_data_in[47:32] = 16'h4C02; loc_valid_in = 4'b0100;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        chk("up_held", 64'(up_valid_out), 64'h0);
        up_ready_in = 1'b1;
        cycle();
        chk("up_release", 64'({up_valid_out, up_data_out}), 64'h1_4C02);

        // Foreign-group flits on the uplink are dropped.
        up_data_in = 16'h8000; up_valid_in = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        chk("drop_one", 64'(drop_count), DROP_EN ? 64'd1 : 64'd0);
        chk("drop_novalid", 64'({up_valid_out, loc_valid_out}), 64'h0);
        up_valid_in = 1'b1;
        repeat (300) cycle();
        idle_inputs();
        repeat (2) cycle();
        chk("drop_sat", 64'(drop_count), DROP_EN ? 64'd255 : 64'd0);

        // Four sources contending for leaf 3.
        loc_data_in[15:0]  = flit(GROUP_ID, 3, 0);
        loc_data_in[47:32] = flit(GROUP_ID, 3, 2);
        loc_data_in[63:48] = flit(GROUP_ID, 3, 3);
        up_data_in         = flit(GROUP_ID, 3, 4);
        loc_valid_in = 4'b1101; up_valid_in = 1'b1;
        cycle();
        for (int n = 0; n < 12; n++) begin
            cycle();
            chk("rr_valid", 64'(loc_valid_out[3]), 64'h1);
            chk("rr_order", 64'(loc_data_out[57:48]), 64'(seq[n % 4]));
        end
        idle_inputs();
        repeat (20) cycle();

        // Fill leaf 0 with uplink-bound flits while the uplink stalls.
        up_ready_in = 1'b0;
        for (int n = 0; n < 5; n++) begin
            loc_data_in[15:0] = flit(5, 0, n); loc_valid_in = 4'b0001;
            cycle();
            if (n == 3) chk("full_ready", 64'(loc_ready_out[0]), 64'h0);
        end
        idle_inputs();
        up_ready_in = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("full_drain", 64'({up_valid_out, up_data_out}), {47'h0, 1'b1, flit(5, 0, n)});
        end
        cycle();
        chk("full_no5th", 64'(up_valid_out), 64'h0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) begin
                loc_data_in[i*16 +: 16] = flit(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : GROUP_ID,
                                               int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            end
            up_data_in = flit(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : GROUP_ID,
                              int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)));
            loc_valid_in = 4'($urandom);
            up_valid_in  = 1'($urandom);
            up_ready_in  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle_inputs();
        up_ready_in = 1'b1;
        repeat (20) cycle();

        // Reset while three flits are queued.
        up_ready_in = 1'b0;
        loc_data_in[31:16] = flit(7, 1, 9); loc_valid_in = 4'b0010;
        repeat (3) cycle();
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valids", 64'({up_valid_out, loc_valid_out}), 64'h0);
        chk("midrst_readies", 64'({up_ready_out, loc_ready_out}), 64'h1F);
        chk("midrst_drop", 64'(drop_count), 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        up_ready_in = 1'b1;
        repeat (10) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
